sti_rx_dac: RTL and testbench
=============================

Name: sti_rx_dac

Overview:
- Receive-side counterpart of the team's serial transmitter and pixel-memory writer.
- Deserializes a framed serial bit stream (si_data/si_valid) into 8/16/24/32-bit words, selectable MSB-first or LSB-first.
- Presents each completed word on a parallel port and writes its bytes into an 8-bit-addressed byte memory.
- On end-of-stream, zero-fills the remaining memory and raises done.

Parameters:
- ADDR_W, 8, memory address width; memory depth is 2**ADDR_W bytes.
- FILL_BYTE, 8'h00, value written during end-of-stream fill.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- si_data  in  1  serial data bit, sampled when si_valid=1
- si_valid  in  1  high for each bit of a frame; a frame is a contiguous run of high cycles
- si_end  in  1  end-of-stream strobe
- cfg_length  in  2  frame size: 00=8, 01=16, 10=24, 11=32 bits
- cfg_msb  in  1  1=first bit is word MSB, 0=first bit is bit 0
- po_data  out  32  assembled word, zero-extended above N bits
- po_valid  out  1  one-cycle pulse, po_data valid
- po_len  out  2  cfg_length of the word on po_data
- frame_err  out  1  one-cycle pulse on a short or aborted frame
- mem_wr  out  1  byte write strobe
- mem_addr  out  ADDR_W  write address
- mem_dataout  out  8  write data
- overflow  out  1  sticky; a word was dropped because memory was full
- done  out  1  level; fill complete, held until reset

Behaviour:
- Reset: every output is 0; write pointer wr_ptr=0; both FSMs in idle.

RX FSM (states R_IDLE, R_SHIFT):
- R_IDLE: when si_valid=1, latch cfg_length and cfg_msb, load N=8*(cfg_length+1), store the first bit, set cnt=1, go to R_SHIFT.
- Bit placement: MSB-first, bit k of the frame goes to position N-1-k; LSB-first, bit k goes to position k.
- Each si_valid=1 cycle stores one bit and increments cnt.
- When the Nth bit is stored: in the next cycle po_data = word and po_valid=1 (latency 1). The word is handed to the WR FSM in the same cycle.
- Back-to-back frames: if si_valid is still 1 in the cycle after the Nth bit, that bit starts a new frame and config is re-sampled in that cycle.
- Short frame (si_valid=0 while in R_SHIFT with cnt<N): frame_err pulses next cycle, bits are discarded, go to R_IDLE.
- si_end while in R_SHIFT: frame_err pulses, partial frame is discarded, end-of-stream is then processed.

WR FSM (states W_IDLE, W_WRITE, W_GAP, W_FILL, W_FGAP, W_DONE):
- On handoff, bytes are written most-significant first: bits [N-1:N-8] first, down to [7:0]; 1-4 bytes.
- W_WRITE: mem_wr=1, mem_addr=wr_ptr, mem_dataout=byte; wr_ptr increments. W_GAP then holds mem_wr=0 for one cycle.
- No two consecutive cycles have mem_wr=1.
- A word takes at most 8 cycles to write, which is less than or equal to the minimum frame time, so one pending-word register suffices.
- Full memory: wr_ptr is ADDR_W+1 bits. When it reaches 2**ADDR_W, further bytes are not written and overflow is set (sticky); po_valid still pulses.
- A partially written word that hits full drops its remaining bytes and sets overflow.
- si_end: latched as end_pending. It is acted on only when the WR FSM is idle (pending word fully written), then go to W_FILL.
- W_FILL/W_FGAP: write FILL_BYTE at wr_ptr..2**ADDR_W-1 with the same 1-cycle gap rule.
- After the last fill write, go to W_DONE with done=1 and mem_wr=0. If already full, go to W_DONE directly.
- In W_DONE, si_valid and si_end are ignored until reset.
- Reset mid-frame or mid-fill aborts immediately; no further mem_wr.

Decomposition:
- Shared package sti_pkg:
  - length encoding constants LEN_8..LEN_32;
  - a function len2bits(len) returning 8..32;
  - RX and WR state enums.
- One natural sub-module, sti_rx_shifter: bit counter, bit placement and word assembly, emitting word/len/valid/err.
- The top level holds the WR FSM and pointer.

Test Plan:
- 16-bit MSB-first frame with bits of 0xA5C3 → po_data=0x0000A5C3 one cycle after the last bit; mem[0]=A5, mem[1]=C3; mem_wr never high on two adjacent cycles.
- 24-bit LSB-first frame with bits LSB-first of 0x123456 → po_data=0x00123456; mem[0..2]=12,34,56.
- Two back-to-back 8-bit frames 0x81 and 0x7E with si_valid held high for 16 cycles → two po_valid pulses 8 cycles apart; mem[0]=81, mem[1]=7E.
- 32-bit frame with si_valid dropped after 20 bits → frame_err pulse, no po_valid, no mem_wr, wr_ptr unchanged.
- Three 8-bit words then si_end → mem[3..255]=00; done=1 after the fill write to address 255; overflow=0.
- 65 32-bit words (260 bytes) → addresses 0..255 written, overflow=1; si_end → done with no fill writes; reset asserted during the run → all outputs 0 immediately.

Source files
------------

// File: rtl/sti_pkg.sv
// Shared types and helpers for the serial receive / byte-memory writer.
package sti_pkg;

  localparam logic [1:0] LEN_8  = 2'b00;
  localparam logic [1:0] LEN_16 = 2'b01;
  localparam logic [1:0] LEN_24 = 2'b10;
  localparam logic [1:0] LEN_32 = 2'b11;

  typedef enum logic {
    R_IDLE,
    R_SHIFT
  } rx_state_t;

  typedef enum logic [2:0] {
    W_IDLE,
    W_WRITE,
    W_GAP,
    W_FILL,
    W_FGAP,
    W_DONE
  } wr_state_t;

  function automatic logic [5:0] len2bits(
    input logic [1:0] len
  );
    logic [5:0] n;
    unique case (len)
      LEN_8:   n = 6'd8;
      LEN_16:  n = 6'd16;
      LEN_24:  n = 6'd24;
      default: n = 6'd32;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sti_rx_shifter.sv
// Frame deserializer: counts bits, places them MSB- or LSB-first,
// and emits a registered word pulse or a frame-error pulse.
module sti_rx_shifter
  import sti_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        si_data,
  input  logic        si_valid,
  input  logic        si_end,
  input  logic [1:0]  cfg_length,
  input  logic        cfg_msb,
  output logic [31:0] word,
  output logic [1:0]  len,
  output logic        valid,
  output logic        err
);

  rx_state_t   state;
  logic [1:0]  len_q;
  logic        msb_q;
  logic [5:0]  cnt;
  logic [31:0] acc;
  logic [5:0]  n_cur;
  logic [5:0]  pos;
  logic [31:0] bitv;

  // In idle the incoming bit is bit 0 of a frame using live config.
  always_comb begin
    n_cur = len2bits(len_q);
    pos   = cnt;
    if (state == R_IDLE) begin
      n_cur = len2bits(cfg_length);
      pos   = cfg_msb ? n_cur - 6'd1 : 6'd0;
    end else if (msb_q) begin
      pos   = n_cur - 6'd1 - cnt;
    end
    bitv = {31'd0, si_data} << pos;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= R_IDLE;
      len_q <= '0;
      msb_q <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      word  <= '0;
      len   <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      case (state)
        R_IDLE: begin
          if (en && si_valid && !si_end) begin
            len_q <= cfg_length;
            msb_q <= cfg_msb;
            acc   <= bitv;
            cnt   <= 6'd1;
            state <= R_SHIFT;
          end
        end
        R_SHIFT: begin
          if (si_end || !si_valid) begin
            err   <= 1'b1;
            state <= R_IDLE;
          end else if (cnt == n_cur - 6'd1) begin
            word  <= acc | bitv;
            len   <= len_q;
            valid <= 1'b1;
            state <= R_IDLE;
          end else begin
            acc <= acc | bitv;
            cnt <= cnt + 6'd1;
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sti_rx_dac.sv
// Serial receiver top: deserialized words are written bytewise into
// memory with a one-cycle gap; end-of-stream fills the rest and ends.
module sti_rx_dac
  import sti_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] FILL_BYTE = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              si_data,
  input  logic              si_valid,
  input  logic              si_end,
  input  logic [1:0]        cfg_length,
  input  logic              cfg_msb,
  output logic [31:0]       po_data,
  output logic              po_valid,
  output logic [1:0]        po_len,
  output logic              frame_err,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_dataout,
  output logic              overflow,
  output logic              done
);

  wr_state_t     state;
  logic [ADDR_W:0] wr_ptr;
  logic [31:0]   pend_word;
  logic [2:0]    pend_nb;
  logic          end_pending;
  logic          full;
  logic          rx_en;
  logic [7:0]    cur_byte;

  assign full  = wr_ptr[ADDR_W];
  assign rx_en = !end_pending && !done;

  sti_rx_shifter u_shift (
    .clk        (clk),
    .reset      (reset),
    .en         (rx_en),
    .si_data    (si_data),
    .si_valid   (si_valid),
    .si_end     (si_end),
    .cfg_length (cfg_length),
    .cfg_msb    (cfg_msb),
    .word       (po_data),
    .len        (po_len),
    .valid      (po_valid),
    .err        (frame_err)
  );

  // pend_nb counts bytes still to write; the top one goes first.
  always_comb begin
    case (pend_nb)
      3'd4:    cur_byte = pend_word[31:24];
      3'd3:    cur_byte = pend_word[23:16];
      3'd2:    cur_byte = pend_word[15:8];
      default: cur_byte = pend_word[7:0];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= W_IDLE;
      wr_ptr      <= '0;
      pend_word   <= '0;
      pend_nb     <= '0;
      end_pending <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_dataout <= '0;
      overflow    <= 1'b0;
      done        <= 1'b0;
    end else begin
      if (si_end && state != W_DONE)
        end_pending <= 1'b1;
      case (state)
        W_IDLE: begin
          if (pend_nb != 3'd0) begin
            if (full) begin
              overflow <= 1'b1;
              pend_nb  <= '0;
            end else begin
              mem_wr      <= 1'b1;
              mem_addr    <= wr_ptr[ADDR_W-1:0];
              mem_dataout <= cur_byte;
              wr_ptr      <= wr_ptr + 1'b1;
              pend_nb     <= pend_nb - 3'd1;
              state       <= W_WRITE;
            end
          end else if (end_pending) begin
            if (full) begin
              done  <= 1'b1;
              state <= W_DONE;
            end else begin
              mem_wr      <= 1'b1;
              mem_addr    <= wr_ptr[ADDR_W-1:0];
              mem_dataout <= FILL_BYTE;
              wr_ptr      <= wr_ptr + 1'b1;
              state       <= W_FILL;
            end
          end
        end
        W_WRITE: begin
          mem_wr <= 1'b0;
          state  <= W_GAP;
        end
        W_GAP: begin
          if (pend_nb == 3'd0) begin
            state <= W_IDLE;
          end else if (full) begin
            overflow <= 1'b1;
            pend_nb  <= '0;
            state    <= W_IDLE;
          end else begin
            mem_wr      <= 1'b1;
            mem_addr    <= wr_ptr[ADDR_W-1:0];
            mem_dataout <= cur_byte;
            wr_ptr      <= wr_ptr + 1'b1;
            pend_nb     <= pend_nb - 3'd1;
            state       <= W_WRITE;
          end
        end
        W_FILL: begin
          mem_wr <= 1'b0;
          state  <= W_FGAP;
        end
        W_FGAP: begin
          if (full) begin
            done  <= 1'b1;
            state <= W_DONE;
          end else begin
            mem_wr      <= 1'b1;
            mem_addr    <= wr_ptr[ADDR_W-1:0];
            mem_dataout <= FILL_BYTE;
            wr_ptr      <= wr_ptr + 1'b1;
            state       <= W_FILL;
          end
        end
        W_DONE: state <= W_DONE;
        default: state <= W_IDLE;
      endcase
      // A fresh word always lands after any consumption this cycle.
      if (po_valid) begin
        pend_word <= po_data;
        pend_nb   <= {1'b0, po_len} + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_sti_rx_dac.sv
// Scoreboard bench for sti_rx_dac: expected words and byte writes are
// queued by the stimulus and popped by a negedge monitor.
module tb_sti_rx_dac;

  localparam int         DEPTH = 256;
  localparam logic [7:0] FILL  = 8'h00;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        si_data = 1'b0;
  logic        si_valid = 1'b0;
  logic        si_end = 1'b0;
  logic [1:0]  cfg_length = 2'b00;
  logic        cfg_msb = 1'b0;
  logic [31:0] po_data;
  logic        po_valid;
  logic [1:0]  po_len;
  logic        frame_err;
  logic        mem_wr;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_dataout;
  logic        overflow;
  logic        done;

  sti_rx_dac #(.ADDR_W(8), .FILL_BYTE(FILL)) dut (
    .clk         (clk),
    .reset       (reset),
    .si_data     (si_data),
    .si_valid    (si_valid),
    .si_end      (si_end),
    .cfg_length  (cfg_length),
    .cfg_msb     (cfg_msb),
    .po_data     (po_data),
    .po_valid    (po_valid),
    .po_len      (po_len),
    .frame_err   (frame_err),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_dataout (mem_dataout),
    .overflow    (overflow),
    .done        (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  len;
    int          due;
  } word_t;

  word_t       wq[$];
  logic [15:0] bq[$];
  int tests = 0;
  int fails = 0;
  int exp_ptr = 0;
  int exp_err = 0;
  int err_seen = 0;
  bit exp_ovf = 0;
  bit prev_wr = 0;

  task automatic check(string name, logic [63:0] got,
                       logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic flag(string name);
    tests++;
    fails++;
    $display("FAIL %s got event want none", name);
  endtask

  function automatic logic [54:0] outs();
    return {po_data, po_valid, po_len, frame_err, mem_wr,
            mem_addr, mem_dataout, overflow, done};
  endfunction

  always @(negedge clk) begin
    word_t       w;
    logic [15:0] b;
    if (reset) begin
      check("reset_quiet", {mem_wr, po_valid, done}, 3'b000);
      prev_wr = 1'b0;
    end else begin
      if (po_valid) begin
        if (wq.size() == 0) begin
          flag("po_unexpected");
        end else begin
          w = wq.pop_front();
          check("po_data", po_data, w.data);
          check("po_len", po_len, w.len);
          check("po_latency", cyc, w.due);
        end
      end
      if (frame_err) err_seen++;
      if (mem_wr) begin
        check("wr_adjacent", prev_wr, 1'b0);
        if (bq.size() == 0) begin
          flag("mem_wr_unexpected");
        end else begin
          b = bq.pop_front();
          check("mem_addr", mem_addr, b[15:8]);
          check("mem_data", mem_dataout, b[7:0]);
        end
      end
      prev_wr = mem_wr;
    end
  end

  // Reference: a word of N bits becomes N/8 bytes, top byte first,
  // at consecutive addresses until memory is full.
  task automatic expect_word(logic [31:0] w, logic [1:0] len,
                             int due);
    int nb;
    wq.push_back('{w, len, due});
    nb = int'(len) + 1;
    for (int b = nb - 1; b >= 0; b--) begin
      if (exp_ptr < DEPTH) begin
        bq.push_back({exp_ptr[7:0], w[8*b +: 8]});
        exp_ptr++;
      end else begin
        exp_ovf = 1'b1;
      end
    end
  endtask

  task automatic send_frame(logic [1:0] len, logic msb,
                            logic [31:0] wi);
    int n;
    logic [31:0] w;
    n = 8 * (int'(len) + 1);
    w = (n == 32) ? wi : (wi & ((32'd1 << n) - 32'd1));
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      si_valid   = 1'b1;
      cfg_length = len;
      cfg_msb    = msb;
      si_data    = msb ? w[n-1-k] : w[k];
    end
    expect_word(w, len, cyc + 1);
  endtask

  task automatic short_frame(logic [1:0] len, int nbits);
    for (int k = 0; k < nbits; k++) begin
      @(posedge clk);
      #1;
      si_valid   = 1'b1;
      cfg_length = len;
      cfg_msb    = 1'b1;
      si_data    = 1'($urandom_range(0, 1));
    end
    exp_err++;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      si_valid = 1'b0;
      si_data  = 1'b0;
    end
  endtask

  task automatic end_stream();
    @(posedge clk);
    #1;
    si_valid = 1'b0;
    si_end   = 1'b1;
    @(posedge clk);
    #1;
    si_end = 1'b0;
    for (int a = exp_ptr; a < DEPTH; a++)
      bq.push_back({a[7:0], FILL});
    if (exp_ptr < DEPTH) exp_ptr = DEPTH;
  endtask

  task automatic wait_done(string tag);
    int i = 0;
    while (!done && i < 4000) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_bytes_left"}, bq.size(), 0);
    idle(6);
    check({tag, "_done_held"}, done, 1'b1);
    check({tag, "_words_left"}, wq.size(), 0);
    check({tag, "_overflow"}, overflow, exp_ovf);
    check({tag, "_frame_err"}, err_seen, exp_err);
  endtask

  task automatic clear_model();
    wq.delete();
    bq.delete();
    exp_ptr  = 0;
    exp_err  = 0;
    err_seen = 0;
    exp_ovf  = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("reset_outputs", outs(), '0);
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", outs(), '0);
    reset = 1'b0;

    send_frame(2'b01, 1'b1, 32'h0000A5C3);
    idle(12);
    send_frame(2'b10, 1'b0, 32'h00123456);
    idle(12);
    send_frame(2'b00, 1'b1, 32'h81);
    send_frame(2'b00, 1'b1, 32'h7E);
    idle(12);
    short_frame(2'b11, 20);
    idle(6);
    check("short_err", err_seen, exp_err);
    for (int i = 0; i < 20; i++) begin
      send_frame(2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 1) == 1)
        idle($urandom_range(1, 12));
    end
    idle(12);
    end_stream();
    wait_done("stream");

    do_reset();
    for (int i = 0; i < 65; i++) begin
      send_frame(2'b11, 1'($urandom_range(0, 1)), $urandom);
      idle($urandom_range(0, 3));
    end
    idle(20);
    check("full_overflow", overflow, 1'b1);
    end_stream();
    wait_done("full");

    do_reset();
    send_frame(2'b00, 1'b1, 32'h11);
    send_frame(2'b00, 1'b0, 32'h22);
    send_frame(2'b00, 1'b1, 32'h33);
    short_frame(2'b01, 10);
    end_stream();
    wait_done("abort_end");

    do_reset();
    for (int i = 0; i < 3; i++)
      send_frame(2'b00, 1'b1, $urandom);
    idle(12);
    end_stream();
    repeat (30) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_fill_reset", outs(), '0);
    clear_model();
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(4);
    check("post_reset_done", done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
